decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- RV32I instruction decode stage, between fetch and execute.
- Accepts one fetched instruction per cycle over a valid/ready handshake.
- Decodes the fields and drives the two synchronous-read register-file ports in the same cycle.
- Presents a registered decode bundle to execute; operand data arrives from the register file aligned with that bundle.

Parameters:
- XLEN, 32, datapath and PC width; only 32 is supported.

Ports:
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- flush  in  1  squash the held and incoming instruction (branch mispredict/trap)
- if_valid  in  1  fetch offers an instruction
- if_ready  out  1  decode accepts this cycle
- if_instr  in  32  instruction word
- if_pc  in  XLEN  instruction address
- rf_read1_valid, rf_read2_valid  out  1  register-file read enables
- rf_read1_addr, rf_read2_addr  out  5  register-file read addresses
- rf_read1_data, rf_read2_data  in  32  register-file read data; valid 1 cycle after enable
- id_valid  out  1  decode bundle valid
- id_ready  in  1  execute consumes the bundle
- id_pc  out  XLEN  held PC
- id_opclass  out  4  LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP, FENCE, SYSTEM, ILLEGAL
- id_funct3  out  3  instr[14:12]
- id_funct7b5  out  1  instr[30]
- id_rd  out  5  destination register
- id_rd_we  out  1  writes rd (and rd != 0)
- id_rs1, id_rs2  out  5  effective source registers (0 if unused)
- id_imm  out  32  sign-extended immediate
- id_rs1_data, id_rs2_data  out  32  pass-through of rf_read1_data / rf_read2_data

Behaviour:
- Handshake:
  - if_ready = ~reset & ~flush & (~id_valid | id_ready).
  - accept = if_valid & if_ready.
- Register update, priority order:
  - reset or flush: id_valid <= 0.
  - accept: load all id_* fields, id_valid <= 1.
  - id_valid & id_ready & ~if_valid: id_valid <= 0.
  - otherwise: hold.
- Reset values: id_valid 0, all other registered outputs 0. The register file resets its own data to 0.
- Register-file drive:
  - On accept: addresses are the decoded effective rs1/rs2 of if_instr.
  - When id_valid & ~id_ready (stall): addresses are the held id_rs1/id_rs2, and both valids are high, so data re-reads every cycle. A writeback to a held source during the stall is therefore reflected one cycle later (via the register-file write bypass).
  - Otherwise (and during reset/flush): valids are 0 and addresses are 0.
- Latency: instruction accepted in cycle N → id_valid and correct id_rs*_data in cycle N+1.
- Effective sources:
  - rs1 is used by JALR, BRANCH, LOAD, STORE, OP_IMM, OP.
  - rs2 is used by BRANCH, STORE, OP.
  - An unused source is forced to 0, so its data reads 0.
- Immediates (RV32I formats, sign bit instr[31]):
  - I: LOAD, OP_IMM, JALR, SYSTEM.
  - S: STORE.
  - B: BRANCH, bit0 = 0.
  - U: LUI, AUIPC, low 12 bits = 0.
  - J: JAL, bit0 = 0.
  - Others: 0.
- id_rd_we = 1 for LUI, AUIPC, JAL, JALR, LOAD, OP_IMM, OP when rd != 0.
- ILLEGAL when any of:
  - instr[1:0] != 2'b11, or unknown opcode;
  - OP with funct7 not 0x00/0x20, or 0x20 with funct3 other than 000/101;
  - OP_IMM shift (funct3 001/101) with instr[31:25] not 0x00 (or 0x20 for 101 only);
  - LOAD funct3 in {011,110,111}; STORE funct3 >= 011; BRANCH funct3 in {010,011}; JALR funct3 != 000.
- ILLEGAL handling: id_rd_we = 0, rs1 = rs2 = 0, the bundle is still delivered valid, and the pipeline handles the trap.
- flush while stalled drops the held bundle; an instruction offered in the flush cycle is not accepted.

Decomposition:
- Shared package cpu_pkg:
  - opclass enum constants;
  - RV32I opcode constants (7'b0110111 etc.);
  - immediate-format enum.
- One combinational sub-module, instr_decoder, maps instr → {opclass, rd, rs1, rs2, imm, rd_we, funct fields}.
- decode_stage owns the handshake, pipeline register and register-file port drive.

Test Plan:
- Decode I-type: reg x2 = 5; present 0xFFF10093 (addi x1,x2,-1) → next cycle id_opclass = OP_IMM, id_rd = 1, id_rd_we = 1, id_rs1 = 2, id_rs2 = 0, id_imm = 0xFFFFFFFF, id_rs1_data = 5.
- Decode store/branch/lui:
  - 0x00532423 (sw x5,8(x6)) → STORE, imm = 8, rd_we = 0, rs1 = 6, rs2 = 5.
  - 0xFE000EE3 (beq x0,x0,-4) → BRANCH, imm = 0xFFFFFFFC.
  - 0x123451B7 (lui x3) → imm = 0x12345000, rs1 = rs2 = 0.
- Stall and refresh: hold id_ready = 0 for 3 cycles after the addi; write x2 = 0xA5 in stall cycle 1 → id_rs1_data = 0xA5 from the next cycle; if_ready = 0 and all fields stable throughout; bundle consumed once id_ready = 1.
- Back-to-back: 4 instructions with if_valid = id_ready = 1 → one bundle per cycle in order, no bubbles, if_ready constantly 1.
- Illegal: 0x00000000, and 0x40001033 (funct7 0x20 with funct3 001) → ILLEGAL, rd_we = 0, id_valid = 1.
- Flush/reset: flush while stalled with a valid instruction offered → id_valid = 0 next cycle, instruction not accepted; reset mid-stall → id_valid = 0, all fields 0, rf valids 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared RV32I definitions for the decode slice.
// Contents: opclass enum, base opcode constants, immediate-format enum,
// the registered decode bundle layout and the immediate builder.
package cpu_pkg;

  typedef enum logic [3:0] {
    OPC_LUI     = 4'd0,
    OPC_AUIPC   = 4'd1,
    OPC_JAL     = 4'd2,
    OPC_JALR    = 4'd3,
    OPC_BRANCH  = 4'd4,
    OPC_LOAD    = 4'd5,
    OPC_STORE   = 4'd6,
    OPC_OP_IMM  = 4'd7,
    OPC_OP      = 4'd8,
    OPC_FENCE   = 4'd9,
    OPC_SYSTEM  = 4'd10,
    OPC_ILLEGAL = 4'd11
  } opclass_t;

  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_FENCE  = 7'b0001111;
  localparam logic [6:0] OPCODE_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_fmt_t;

  // Everything execute needs about one instruction, held in the pipeline register.
  typedef struct packed {
    logic [31:0] pc;
    opclass_t    opclass;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [4:0]  rd;
    logic        rd_we;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } decode_bundle_t;

  // Sign-extended immediate; bit 31 of the instruction is always the sign.
  function automatic logic [31:0] build_imm(input imm_fmt_t fmt, input logic [31:0] instr);
    logic [31:0] imm;
    case (fmt)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'b0};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = 32'b0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/decode_stage_decoder.sv
// instr_decoder: purely combinational RV32I field decoder.
// Ports:
//   instr     in  32  instruction word
//   opclass   out 4   opclass_t code (OPC_ILLEGAL for anything not RV32I)
//   funct3    out 3   instr[14:12]
//   funct7b5  out 1   instr[30]
//   rd        out 5   instr[11:7]
//   rd_we     out 1   instruction writes a non-zero rd
//   rs1, rs2  out 5   effective sources, 0 when the opclass does not read them
//   imm       out 32  sign-extended immediate, 0 for formats without one
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [31:0] instr,
  output logic [3:0]  opclass,
  output logic [2:0]  funct3,
  output logic        funct7b5,
  output logic [4:0]  rd,
  output logic        rd_we,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [31:0] imm
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  opclass_t   cls;
  imm_fmt_t   fmt;
  logic       use_rs1;
  logic       use_rs2;
  logic       writes_rd;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];

  // Only a legal encoding sets cls away from ILLEGAL; the use/write flags are
  // raised in the same branch, so an illegal word never reads or writes registers.
  always_comb begin
    cls       = OPC_ILLEGAL;
    fmt       = IMM_NONE;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    writes_rd = 1'b0;
    if (instr[1:0] == 2'b11) begin
      case (opcode)
        OPCODE_LUI: begin
          cls = OPC_LUI; fmt = IMM_U; writes_rd = 1'b1;
        end
        OPCODE_AUIPC: begin
          cls = OPC_AUIPC; fmt = IMM_U; writes_rd = 1'b1;
        end
        OPCODE_JAL: begin
          cls = OPC_JAL; fmt = IMM_J; writes_rd = 1'b1;
        end
        OPCODE_JALR: begin
          if (f3 == 3'b000) begin
            cls = OPC_JALR; fmt = IMM_I; use_rs1 = 1'b1; writes_rd = 1'b1;
          end
        end
        OPCODE_BRANCH: begin
          if (f3 != 3'b010 && f3 != 3'b011) begin
            cls = OPC_BRANCH; fmt = IMM_B; use_rs1 = 1'b1; use_rs2 = 1'b1;
          end
        end
        OPCODE_LOAD: begin
          if (f3 != 3'b011 && f3 != 3'b110 && f3 != 3'b111) begin
            cls = OPC_LOAD; fmt = IMM_I; use_rs1 = 1'b1; writes_rd = 1'b1;
          end
        end
        OPCODE_STORE: begin
          if (f3 < 3'b011) begin
            cls = OPC_STORE; fmt = IMM_S; use_rs1 = 1'b1; use_rs2 = 1'b1;
          end
        end
        OPCODE_OP_IMM: begin
          // Shifts reuse imm[11:5] as funct7; only SRAI may set bit 30.
          if ((f3 == 3'b001 && f7 != 7'h00) ||
              (f3 == 3'b101 && f7 != 7'h00 && f7 != 7'h20)) begin
            cls = OPC_ILLEGAL;
          end else begin
            cls = OPC_OP_IMM; fmt = IMM_I; use_rs1 = 1'b1; writes_rd = 1'b1;
          end
        end
        OPCODE_OP: begin
          if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101))) begin
            cls = OPC_OP; use_rs1 = 1'b1; use_rs2 = 1'b1; writes_rd = 1'b1;
          end
        end
        OPCODE_FENCE: begin
          cls = OPC_FENCE;
        end
        OPCODE_SYSTEM: begin
          cls = OPC_SYSTEM; fmt = IMM_I;
        end
        default: cls = OPC_ILLEGAL;
      endcase
    end
  end

  assign opclass  = cls;
  assign funct3   = f3;
  assign funct7b5 = instr[30];
  assign rd       = instr[11:7];
  assign rd_we    = writes_rd & (instr[11:7] != 5'd0);
  assign rs1      = use_rs1 ? instr[19:15] : 5'd0;
  assign rs2      = use_rs2 ? instr[24:20] : 5'd0;
  assign imm      = build_imm(fmt, instr);

endmodule

// File: rtl/decode_stage.sv
// decode_stage: RV32I decode between fetch and execute.
// Accepts one instruction per cycle (if_valid/if_ready), decodes it, launches
// the synchronous register-file reads in the same cycle and presents a
// registered bundle (id_valid/id_ready) whose operand data arrives from the
// register file aligned with it one cycle later.
// Ports:
//   clock, reset             clock; synchronous active-high reset
//   flush                    drops the held bundle and refuses the offered one
//   if_valid/if_ready/if_instr/if_pc      fetch side
//   rf_read{1,2}_valid/_addr/_data        register-file read ports
//   id_valid/id_ready and id_* fields     execute side
//   id_rs{1,2}_data          straight pass-through of the register-file data
module decode_stage
  import cpu_pkg::*;
#(
  parameter int XLEN = 32  // only 32 is supported
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  output logic            rf_read1_valid,
  output logic            rf_read2_valid,
  output logic [4:0]      rf_read1_addr,
  output logic [4:0]      rf_read2_addr,
  input  logic [31:0]     rf_read1_data,
  input  logic [31:0]     rf_read2_data,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [3:0]      id_opclass,
  output logic [2:0]      id_funct3,
  output logic            id_funct7b5,
  output logic [4:0]      id_rd,
  output logic            id_rd_we,
  output logic [4:0]      id_rs1,
  output logic [4:0]      id_rs2,
  output logic [31:0]     id_imm,
  output logic [31:0]     id_rs1_data,
  output logic [31:0]     id_rs2_data
);

  logic [3:0]     dec_opclass;
  logic [2:0]     dec_funct3;
  logic           dec_funct7b5;
  logic [4:0]     dec_rd;
  logic           dec_rd_we;
  logic [4:0]     dec_rs1;
  logic [4:0]     dec_rs2;
  logic [31:0]    dec_imm;

  logic           valid_reg;
  decode_bundle_t bundle_reg;
  decode_bundle_t bundle_next;
  logic           accept;
  logic           stall;

  instr_decoder u_decoder (
    .instr    (if_instr),
    .opclass  (dec_opclass),
    .funct3   (dec_funct3),
    .funct7b5 (dec_funct7b5),
    .rd       (dec_rd),
    .rd_we    (dec_rd_we),
    .rs1      (dec_rs1),
    .rs2      (dec_rs2),
    .imm      (dec_imm)
  );

  assign if_ready = ~reset & ~flush & (~valid_reg | id_ready);
  assign accept   = if_valid & if_ready;
  // Holding a bundle execute has not taken; reset/flush take precedence.
  assign stall    = ~reset & ~flush & valid_reg & ~id_ready;

  always_comb begin
    bundle_next          = '0;
    bundle_next.pc       = if_pc;
    bundle_next.opclass  = opclass_t'(dec_opclass);
    bundle_next.funct3   = dec_funct3;
    bundle_next.funct7b5 = dec_funct7b5;
    bundle_next.rd       = dec_rd;
    bundle_next.rd_we    = dec_rd_we;
    bundle_next.rs1      = dec_rs1;
    bundle_next.rs2      = dec_rs2;
    bundle_next.imm      = dec_imm;
  end

  // Flush only clears valid; the stale fields are harmless behind id_valid = 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_reg  <= 1'b0;
      bundle_reg <= '0;
    end else if (flush) begin
      valid_reg  <= 1'b0;
    end else if (accept) begin
      valid_reg  <= 1'b1;
      bundle_reg <= bundle_next;
    end else if (valid_reg & id_ready & ~if_valid) begin
      valid_reg  <= 1'b0;
    end
  end

  // Re-reading the held sources every stall cycle keeps id_rs*_data current
  // when writeback lands on one of them while execute is blocked.
  always_comb begin
    rf_read1_valid = 1'b0;
    rf_read2_valid = 1'b0;
    rf_read1_addr  = 5'd0;
    rf_read2_addr  = 5'd0;
    if (accept) begin
      rf_read1_valid = 1'b1;
      rf_read2_valid = 1'b1;
      rf_read1_addr  = dec_rs1;
      rf_read2_addr  = dec_rs2;
    end else if (stall) begin
      rf_read1_valid = 1'b1;
      rf_read2_valid = 1'b1;
      rf_read1_addr  = bundle_reg.rs1;
      rf_read2_addr  = bundle_reg.rs2;
    end
  end

  assign id_valid    = valid_reg;
  assign id_pc       = bundle_reg.pc;
  assign id_opclass  = bundle_reg.opclass;
  assign id_funct3   = bundle_reg.funct3;
  assign id_funct7b5 = bundle_reg.funct7b5;
  assign id_rd       = bundle_reg.rd;
  assign id_rd_we    = bundle_reg.rd_we;
  assign id_rs1      = bundle_reg.rs1;
  assign id_rs2      = bundle_reg.rs2;
  assign id_imm      = bundle_reg.imm;
  assign id_rs1_data = rf_read1_data;
  assign id_rs2_data = rf_read2_data;

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;
  import cpu_pkg::*;

  logic        clock = 1'b0;
  logic        reset, flush, if_valid, id_ready;
  logic [31:0] if_instr, if_pc;
  logic        if_ready, id_valid;
  logic        rf_read1_valid, rf_read2_valid;
  logic [4:0]  rf_read1_addr, rf_read2_addr;
  logic [31:0] rf_read1_data, rf_read2_data;
  logic [31:0] id_pc, id_imm, id_rs1_data, id_rs2_data;
  logic [3:0]  id_opclass;
  logic [2:0]  id_funct3;
  logic        id_funct7b5, id_rd_we;
  logic [4:0]  id_rd, id_rs1, id_rs2;

  // register-file write port driven by the bench (stands in for writeback)
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;

  always #5 clock = ~clock;

  decode_stage #(.XLEN(32)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .rf_read1_valid(rf_read1_valid), .rf_read2_valid(rf_read2_valid),
    .rf_read1_addr(rf_read1_addr), .rf_read2_addr(rf_read2_addr),
    .rf_read1_data(rf_read1_data), .rf_read2_data(rf_read2_data),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
    .id_opclass(id_opclass), .id_funct3(id_funct3), .id_funct7b5(id_funct7b5),
    .id_rd(id_rd), .id_rd_we(id_rd_we), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_imm(id_imm), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data)
  );

  // Register-file environment: synchronous read, write bypass, x0 reads 0.
  logic [31:0] rf_mem [32];
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf_mem[i] <= 32'd0;
      rf_read1_data <= 32'd0;
      rf_read2_data <= 32'd0;
    end else begin
      if (wr_en && wr_addr != 5'd0) rf_mem[wr_addr] <= wr_data;
      if (rf_read1_valid)
        rf_read1_data <= (rf_read1_addr == 5'd0) ? 32'd0 :
                         (wr_en && wr_addr == rf_read1_addr) ? wr_data : rf_mem[rf_read1_addr];
      if (rf_read2_valid)
        rf_read2_data <= (rf_read2_addr == 5'd0) ? 32'd0 :
                         (wr_en && wr_addr == rf_read2_addr) ? wr_data : rf_mem[rf_read2_addr];
    end
  end

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  opc;
    logic [2:0]  f3;
    logic        f7b5;
    logic [4:0]  rd;
    logic        we;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } bundle_t;

  // Reference decode: legality as a separate predicate, immediates by arithmetic.
  function automatic bundle_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
    bundle_t            b;
    logic signed [31:0] s;
    logic [6:0]         op, f7;
    logic [2:0]         f3;
    logic               u1, u2, w, bad;
    logic [31:0]        imm;
    logic [3:0]         opc;
    s = ins; op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    u1 = 0; u2 = 0; w = 0; imm = 0; opc = 4'(OPC_ILLEGAL);
    case (op)
      7'b0110111: begin opc = 4'(OPC_LUI);    w = 1; imm = ins & 32'hFFFFF000; end
      7'b0010111: begin opc = 4'(OPC_AUIPC);  w = 1; imm = ins & 32'hFFFFF000; end
      7'b1101111: begin opc = 4'(OPC_JAL);    w = 1;
        imm = 32'((s >>> 31) << 20) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1); end
      7'b1100111: begin opc = 4'(OPC_JALR);   w = 1; u1 = 1; imm = 32'(s >>> 20); end
      7'b1100011: begin opc = 4'(OPC_BRANCH); u1 = 1; u2 = 1;
        imm = 32'((s >>> 31) << 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1); end
      7'b0000011: begin opc = 4'(OPC_LOAD);   w = 1; u1 = 1; imm = 32'(s >>> 20); end
      7'b0100011: begin opc = 4'(OPC_STORE);  u1 = 1; u2 = 1;
        imm = 32'((s >>> 25) << 5) | 32'(ins[11:7]); end
      7'b0010011: begin opc = 4'(OPC_OP_IMM); w = 1; u1 = 1; imm = 32'(s >>> 20); end
      7'b0110011: begin opc = 4'(OPC_OP);     w = 1; u1 = 1; u2 = 1; end
      7'b0001111: begin opc = 4'(OPC_FENCE); end
      7'b1110011: begin opc = 4'(OPC_SYSTEM); imm = 32'(s >>> 20); end
      default:    opc = 4'(OPC_ILLEGAL);
    endcase
    bad = (ins[1:0] != 2'b11)
       || (op == 7'b0110011 && !(f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5))))
       || (op == 7'b0010011 && f3 == 1 && f7 != 0)
       || (op == 7'b0010011 && f3 == 5 && f7 != 0 && f7 != 7'h20)
       || (op == 7'b0000011 && (f3 == 3 || f3 == 6 || f3 == 7))
       || (op == 7'b0100011 && f3 >= 3)
       || (op == 7'b1100011 && (f3 == 2 || f3 == 3))
       || (op == 7'b1100111 && f3 != 0);
    if (bad || opc == 4'(OPC_ILLEGAL)) begin
      opc = 4'(OPC_ILLEGAL); u1 = 0; u2 = 0; w = 0; imm = 0;
    end
    b.pc = pc; b.opc = opc; b.f3 = f3; b.f7b5 = ins[30]; b.rd = ins[11:7];
    b.we = w && (ins[11:7] != 0);
    b.rs1 = u1 ? ins[19:15] : 5'd0;
    b.rs2 = u2 ? ins[24:20] : 5'd0;
    b.imm = imm;
    return b;
  endfunction

  int          errors = 0;
  int          checks = 0;
  logic        model_on = 1'b0;
  logic        exp_valid;
  bundle_t     exp_b;
  logic [31:0] ref_mem [32];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic rdy, input logic fl);
    if_valid = v; if_instr = ins; if_pc = pc; id_ready = rdy; flush = fl;
  endtask

  // One clock: compare against the model near the falling edge, then advance
  // the model with the inputs that were presented at the rising edge.
  task automatic tick();
    logic    exp_ifr, acc, stl;
    bundle_t d;
    #4;
    exp_ifr = !reset && !flush && (!exp_valid || id_ready);
    acc     = if_valid && exp_ifr;
    stl     = !reset && !flush && exp_valid && !id_ready;
    d       = ref_decode(if_instr, if_pc);
    if (model_on) begin
      chk("if_ready", 32'(if_ready), 32'(exp_ifr));
      chk("id_valid", 32'(id_valid), 32'(exp_valid));
      chk("id_pc", id_pc, exp_b.pc);
      chk("id_opclass", 32'(id_opclass), 32'(exp_b.opc));
      chk("id_funct3", 32'(id_funct3), 32'(exp_b.f3));
      chk("id_funct7b5", 32'(id_funct7b5), 32'(exp_b.f7b5));
      chk("id_rd", 32'(id_rd), 32'(exp_b.rd));
      chk("id_rd_we", 32'(id_rd_we), 32'(exp_b.we));
      chk("id_rs1", 32'(id_rs1), 32'(exp_b.rs1));
      chk("id_rs2", 32'(id_rs2), 32'(exp_b.rs2));
      chk("id_imm", id_imm, exp_b.imm);
      if (exp_valid) begin
        chk("id_rs1_data", id_rs1_data, ref_mem[exp_b.rs1]);
        chk("id_rs2_data", id_rs2_data, ref_mem[exp_b.rs2]);
      end
      chk("rf_read1_valid", 32'(rf_read1_valid), 32'(acc || stl));
      chk("rf_read2_valid", 32'(rf_read2_valid), 32'(acc || stl));
      chk("rf_read1_addr", 32'(rf_read1_addr), acc ? 32'(d.rs1) : stl ? 32'(exp_b.rs1) : 32'd0);
      chk("rf_read2_addr", 32'(rf_read2_addr), acc ? 32'(d.rs2) : stl ? 32'(exp_b.rs2) : 32'd0);
      if (acc) $display("accept pc=%h instr=%h opclass=%0d", if_pc, if_instr, d.opc);
    end
    @(posedge clock);
    if (reset) begin
      exp_valid = 1'b0; exp_b = '0;
      for (int i = 0; i < 32; i++) ref_mem[i] = 32'd0;
    end else begin
      if (wr_en && wr_addr != 5'd0) ref_mem[wr_addr] = wr_data;
      if (flush) exp_valid = 1'b0;
      else if (acc) begin exp_b = d; exp_valid = 1'b1; end
      else if (exp_valid && id_ready && !if_valid) exp_valid = 1'b0;
    end
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    int          sel;
    ins = $urandom;
    sel = $urandom_range(0, 13);
    case (sel)
      0:  ins[6:0] = 7'b0110111;
      1:  ins[6:0] = 7'b0010111;
      2:  ins[6:0] = 7'b1101111;
      3:  ins[6:0] = 7'b1100111;
      4:  ins[6:0] = 7'b1100011;
      5:  ins[6:0] = 7'b0000011;
      6:  ins[6:0] = 7'b0100011;
      7:  ins[6:0] = 7'b0010011;
      8:  ins[6:0] = 7'b0110011;
      9:  ins[6:0] = 7'b0001111;
      10: ins[6:0] = 7'b1110011;
      default: ;
    endcase
    if ((sel == 7 || sel == 8) && ($urandom % 4 != 0))
      ins[31:25] = ($urandom % 2 == 0) ? 7'h00 : 7'h20;
    if ((sel == 3) && ($urandom % 2 == 0)) ins[14:12] = 3'b000;
    return ins;
  endfunction

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  opc;
    logic [4:0]  rd;
    logic        we;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] d1;
    logic [31:0] d2;
  } vec_t;

  vec_t vt [11];

  initial begin
    vt[0]  = '{32'hFFF10093, 4'(OPC_OP_IMM),  5'd1,  1'b1, 5'd2, 5'd0, 32'hFFFFFFFF, 32'd5, 32'd0};
    vt[1]  = '{32'h00532423, 4'(OPC_STORE),   5'd8,  1'b0, 5'd6, 5'd5, 32'h00000008, 32'd0, 32'd0};
    vt[2]  = '{32'hFE000EE3, 4'(OPC_BRANCH),  5'd29, 1'b0, 5'd0, 5'd0, 32'hFFFFFFFC, 32'd0, 32'd0};
    vt[3]  = '{32'h123451B7, 4'(OPC_LUI),     5'd3,  1'b1, 5'd0, 5'd0, 32'h12345000, 32'd0, 32'd0};
    vt[4]  = '{32'h00000000, 4'(OPC_ILLEGAL), 5'd0,  1'b0, 5'd0, 5'd0, 32'h00000000, 32'd0, 32'd0};
    vt[5]  = '{32'h40001033, 4'(OPC_ILLEGAL), 5'd0,  1'b0, 5'd0, 5'd0, 32'h00000000, 32'd0, 32'd0};
    vt[6]  = '{32'h002081B3, 4'(OPC_OP),      5'd3,  1'b1, 5'd1, 5'd2, 32'h00000000, 32'd0, 32'd5};
    vt[7]  = '{32'h008000EF, 4'(OPC_JAL),     5'd1,  1'b1, 5'd0, 5'd0, 32'h00000008, 32'd0, 32'd0};
    vt[8]  = '{32'h40335293, 4'(OPC_OP_IMM),  5'd5,  1'b1, 5'd6, 5'd0, 32'h00000403, 32'd0, 32'd0};
    vt[9]  = '{32'hFF812383, 4'(OPC_LOAD),    5'd7,  1'b1, 5'd2, 5'd0, 32'hFFFFFFF8, 32'd5, 32'd0};
    vt[10] = '{32'h00013083, 4'(OPC_ILLEGAL), 5'd1,  1'b0, 5'd0, 5'd0, 32'h00000000, 32'd0, 32'd0};

    reset = 1'b1; wr_en = 1'b0; wr_addr = 5'd0; wr_data = 32'd0;
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    @(posedge clock); #1;
    exp_valid = 1'b0; exp_b = '0;
    for (int i = 0; i < 32; i++) ref_mem[i] = 32'd0;
    model_on = 1'b1;

    // reset state
    tick();
    chk("reset id_valid", 32'(id_valid), 32'd0);
    chk("reset id_pc", id_pc, 32'd0);
    chk("reset id_imm", id_imm, 32'd0);
    chk("reset if_ready", 32'(if_ready), 32'd0);
    reset = 1'b0;

    // preload x2 = 5
    wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'd5;
    tick();
    wr_en = 1'b0;

    // table: back-to-back with if_valid = id_ready = 1
    for (int i = 0; i < 11; i++) begin
      drive(1'b1, vt[i].instr, 32'h100 + 32'(4 * i), 1'b1, 1'b0);
      tick();
      chk("vec id_valid", 32'(id_valid), 32'd1);
      chk("vec if_ready", 32'(if_ready), 32'd1);
      chk("vec id_pc", id_pc, 32'h100 + 32'(4 * i));
      chk("vec id_opclass", 32'(id_opclass), 32'(vt[i].opc));
      chk("vec id_rd", 32'(id_rd), 32'(vt[i].rd));
      chk("vec id_rd_we", 32'(id_rd_we), 32'(vt[i].we));
      chk("vec id_rs1", 32'(id_rs1), 32'(vt[i].rs1));
      chk("vec id_rs2", 32'(id_rs2), 32'(vt[i].rs2));
      chk("vec id_imm", id_imm, vt[i].imm);
      chk("vec id_rs1_data", id_rs1_data, vt[i].d1);
      chk("vec id_rs2_data", id_rs2_data, vt[i].d2);
      $display("vector %0d instr=%h opclass=%0d imm=%h", i, vt[i].instr, id_opclass, id_imm);
    end
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    tick();
    chk("drain id_valid", 32'(id_valid), 32'd0);

    // stall with writeback to a held source
    drive(1'b1, 32'hFFF10093, 32'h200, 1'b1, 1'b0);
    tick();
    drive(1'b1, 32'h123451B7, 32'h204, 1'b0, 1'b0);
    wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'hA5;
    #1;
    chk("stall0 if_ready", 32'(if_ready), 32'd0);
    chk("stall0 rs1_data", id_rs1_data, 32'd5);
    tick();
    wr_en = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      chk("stall rs1_data", id_rs1_data, 32'hA5);
      chk("stall id_pc", id_pc, 32'h200);
      chk("stall opclass", 32'(id_opclass), 32'(OPC_OP_IMM));
      chk("stall if_ready", 32'(if_ready), 32'd0);
      $display("stall cycle %0d rs1_data=%h", c, id_rs1_data);
      if (c < 3) tick();
    end
    drive(1'b1, 32'h123451B7, 32'h204, 1'b1, 1'b0);
    tick();
    chk("release opclass", 32'(id_opclass), 32'(OPC_LUI));
    chk("release id_pc", id_pc, 32'h204);
    chk("release id_imm", id_imm, 32'h12345000);

    // flush while stalled with an instruction offered
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h002081B3, 32'h300, 1'b0, 1'b1);
    #1;
    chk("flush if_ready", 32'(if_ready), 32'd0);
    tick();
    chk("flush id_valid", 32'(id_valid), 32'd0);
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    tick();
    chk("post-flush id_valid", 32'(id_valid), 32'd0);
    chk("post-flush id_pc", id_pc, 32'h204);
    $display("flush dropped held bundle, offered pc=300 refused");

    // reset in the middle of a stall
    drive(1'b1, 32'hFF812383, 32'h400, 1'b1, 1'b0);
    tick();
    drive(1'b1, 32'h002081B3, 32'h404, 1'b0, 1'b0);
    tick();
    reset = 1'b1;
    #1;
    chk("rst rf_read1_valid", 32'(rf_read1_valid), 32'd0);
    tick();
    chk("rst id_valid", 32'(id_valid), 32'd0);
    chk("rst id_pc", id_pc, 32'd0);
    chk("rst id_opclass", 32'(id_opclass), 32'd0);
    chk("rst id_rs1", 32'(id_rs1), 32'd0);
    chk("rst id_imm", id_imm, 32'd0);
    chk("rst rf_read2_valid", 32'(rf_read2_valid), 32'd0);
    chk("rst if_ready", 32'(if_ready), 32'd0);
    $display("reset mid-stall cleared bundle");
    reset = 1'b0;

    // randomized traffic against the reference model
    for (int n = 0; n < 1500; n++) begin
      drive($urandom % 4 != 0, rand_instr(), $urandom & 32'hFFFFFFFC,
            $urandom % 3 != 0, $urandom % 25 == 0);
      reset   = ($urandom % 200 == 0);
      wr_en   = ($urandom % 2 == 0);
      wr_addr = 5'($urandom_range(1, 31));
      wr_data = $urandom;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
